// File: rtl/gate_test_pkg.sv
// gate_test_pkg: shared FSM states, reference truth tables and limits for the gate self-test path
package gate_test_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam logic [63:0] AND3 = 64'h80;
  localparam logic [63:0] OR3 = 64'hFE;
  localparam logic [63:0] XOR3 = 64'h96;
  localparam int MAX_N_IN = 6;
endpackage

// File: rtl/truth_checker_if.sv
// truth_checker_if: vector/response handshake between a stimulus source and the checker
interface truth_checker_if #(parameter int N_IN = 3);
  logic vec_valid;
  logic vec_ready;
  logic [N_IN-1:0] vec_in;
  logic dut_out;
  logic vec_last;
  modport master (output vec_valid, vec_in, dut_out, vec_last, input vec_ready);
  modport slave (input vec_valid, vec_in, dut_out, vec_last, output vec_ready);
endinterface

// File: rtl/truth_checker_coverage_tracker.sv
// coverage_tracker: seen mask over all 2^N_IN vectors with clear/set and completion detect
module coverage_tracker #(
  parameter int N_IN = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            set_i,
  input  logic [N_IN-1:0] idx_i,
  output logic            cov_full_o,
  output logic            completes_o
);
  localparam int NV = 1 << N_IN;
  logic [NV-1:0] seen_q, seen_d, hot;
  always_comb begin
    hot = NV'(1) << idx_i;
    seen_d = clr_i ? '0 : set_i ? (seen_q | hot) : seen_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) seen_q <= '0;
    else seen_q <= seen_d;
  assign cov_full_o = &seen_q;
  assign completes_o = set_i & ~clr_i & ~cov_full_o & (&(seen_q | hot));
endmodule

// File: rtl/truth_checker.sv
// truth_checker: compares gate responses against a truth table, tracking coverage,
// mismatch count and first failing vector, then reports a pass/fail verdict.
module truth_checker
  import gate_test_pkg::*;
#(
  parameter int          N_IN  = 3,
  parameter logic [63:0] TRUTH = AND3,
  parameter int          CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  truth_checker_if.slave   vif,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_valid,
  output logic             cov_full
);
  localparam logic [(1<<N_IN)-1:0] TT = TRUTH[(1<<N_IN)-1:0];
  state_e state_q, state_d;
  logic ready_q, ready_d, pass_q, pass_d, ffv_q, ffv_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;
  logic acc, mism, term, completes;
  coverage_tracker #(.N_IN(N_IN)) u_cov (
    .clk(clk), .rst_n(rst_n), .clr_i(start), .set_i(acc), .idx_i(vif.vec_in),
    .cov_full_o(cov_full), .completes_o(completes)
  );
  // start outranks a coincident accept: the vector is dropped and results clear
  always_comb begin
    acc = vif.vec_valid & ready_q & ~start;
    mism = vif.dut_out != TT[vif.vec_in];
    term = acc & (vif.vec_last | completes);
    state_d = start ? RUN : term ? DONE : state_q;
    ready_d = state_d == RUN;
    err_d = start ? '0 : (acc & mism & ~&err_q) ? err_q + 1'b1 : err_q;
    ffv_d = start ? 1'b0 : ffv_q | (acc & mism);
    ffvec_d = start ? '0 : (acc & mism & ~ffv_q) ? vif.vec_in : ffvec_q;
    pass_d = start ? 1'b0 : term ? ((err_d == '0) & (cov_full | completes)) : pass_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      pass_q <= 1'b0;
      ffv_q <= 1'b0;
      err_q <= '0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      pass_q <= pass_d;
      ffv_q <= ffv_d;
      err_q <= err_d;
      ffvec_q <= ffvec_d;
    end
  assign vif.vec_ready = ready_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign pass = pass_q;
  assign err_count = err_q;
  assign first_fail_vec = ffvec_q;
  assign first_fail_valid = ffv_q;
endmodule

// File: tb/tb_truth_checker.sv
// tb_truth_checker: table-driven directed checks of truth_checker as a 3-input AND checker
module tb_truth_checker;
  import gate_test_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, pass, first_fail_valid, cov_full;
  logic [7:0] err_count;
  logic [2:0] first_fail_vec;
  int tests = 0, fails = 0;
  truth_checker_if #(.N_IN(3)) vif();
  truth_checker #(.N_IN(3), .TRUTH(AND3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vif(vif), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_fail_vec(first_fail_vec),
    .first_fail_valid(first_fail_valid), .cov_full(cov_full)
  );
  always #5 clk = ~clk;

  typedef struct packed {
    logic st, va;
    logic [2:0] v;
    logic o, l;
    logic [16:0] exp;
  } row_t;
  row_t rows[$];

  function automatic logic [16:0] ex(input logic b, d, p, rdy, cov, ffv, input logic [2:0] fv, input logic [7:0] e);
    return {b, d, p, rdy, cov, ffv, fv, e};
  endfunction
  function automatic row_t r(input logic st, va, input logic [2:0] v, input logic o, l, input logic [16:0] e);
    return '{st: st, va: va, v: v, o: o, l: l, exp: e};
  endfunction
  function automatic logic [16:0] snap();
    return {busy, done, pass, vif.vec_ready, cov_full, first_fail_valid, first_fail_vec, err_count};
  endfunction

  task automatic step(input logic st, va, input logic [2:0] v, input logic o, l);
    start = st; vif.vec_valid = va; vif.vec_in = v; vif.dut_out = o; vif.vec_last = l;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %05h expected %05h {busy,done,pass,ready,cov,ffv,ffvec,err}", name, act, exp);
    end
  endtask

  localparam logic [16:0] RUN0 = 17'h1_2000;
  initial begin
    rows.push_back(r(1, 0, 0, 0, 0, ex(1, 0, 0, 1, 0, 0, 0, 0)));
    for (int i = 0; i < 7; i++) rows.push_back(r(0, 1, 3'(i), 0, 0, ex(1, 0, 0, 1, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 7, 1, 1, ex(0, 1, 1, 0, 1, 0, 0, 0)));
    rows.push_back(r(0, 1, 3, 1, 0, ex(0, 1, 1, 0, 1, 0, 0, 0)));
    rows.push_back(r(1, 0, 0, 0, 0, ex(1, 0, 0, 1, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 0, 0, 0, ex(1, 0, 0, 1, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 1, 0, 0, ex(1, 0, 0, 1, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 2, 1, 0, ex(1, 0, 0, 1, 0, 1, 2, 1)));
    for (int i = 3; i < 7; i++) rows.push_back(r(0, 1, 3'(i), 0, 0, ex(1, 0, 0, 1, 0, 1, 2, 1)));
    rows.push_back(r(0, 1, 7, 0, 1, ex(0, 1, 0, 0, 1, 1, 2, 2)));
    rows.push_back(r(1, 0, 0, 0, 0, ex(1, 0, 0, 1, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 0, 0, 0, ex(1, 0, 0, 1, 0, 0, 0, 0)));
    rows.push_back(r(0, 0, 5, 1, 0, ex(1, 0, 0, 1, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 1, 0, 0, ex(1, 0, 0, 1, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 7, 1, 1, ex(0, 1, 0, 0, 0, 0, 0, 0)));
    rows.push_back(r(1, 0, 0, 0, 0, ex(1, 0, 0, 1, 0, 0, 0, 0)));
    for (int i = 7; i > 0; i--) rows.push_back(r(0, 1, 3'(i), i == 7, 0, ex(1, 0, 0, 1, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 0, 0, 0, ex(0, 1, 1, 0, 1, 0, 0, 0)));

    vif.vec_valid = 0; vif.vec_in = 0; vif.dut_out = 0; vif.vec_last = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", snap(), '0);
    rst_n = 1'b1;
    step(0, 1, 5, 1, 0);
    chk("idle_ignore", snap(), '0);
    foreach (rows[i]) begin
      step(rows[i].st, rows[i].va, rows[i].v, rows[i].o, rows[i].l);
      chk($sformatf("row%0d", i), snap(), rows[i].exp);
    end

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      step(0, 1, 5, 1, 0);
      if (i == 9) chk("sat_10", snap(), ex(1, 0, 0, 1, 0, 1, 5, 10));
      if (i == 254) chk("sat_255", snap(), ex(1, 0, 0, 1, 0, 1, 5, 255));
    end
    chk("sat_hold", snap(), ex(1, 0, 0, 1, 0, 1, 5, 255));

    step(1, 1, 5, 1, 0);
    chk("start_wins", snap(), RUN0);
    step(0, 1, 6, 1, 0);
    chk("after_start", snap(), ex(1, 0, 0, 1, 0, 1, 6, 1));

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 3'(i), 0, 0);
    chk("pre_reset", snap(), RUN0);
    rst_n = 1'b0;
    #1;
    chk("async_reset", snap(), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 5, 1, 1);
      chk($sformatf("post_reset%0d", i), snap(), '0);
    end
    step(1, 1, 5, 1, 0);
    chk("restart", snap(), RUN0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
